// File: rtl/instr_fetch_queue_if.sv
// Program-memory read port between the fetch queue and the ROM/RAM.
// Latency: none (wires only).
// Backpressure: none; the requester keeps at most one read outstanding.
// Ports: mem_req/mem_addr (request, one-cycle pulse), mem_rvalid/mem_rdata (in-order read return).
interface instr_fetch_queue_if #(
   parameter int ADDR_W = 16
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rvalid;
   logic [15:0]       mem_rdata;

   // master = fetch queue (issues reads), slave = program memory
   modport master (output mem_req, output mem_addr, input mem_rvalid, input mem_rdata);
   modport slave  (input mem_req, input mem_addr, output mem_rvalid, output mem_rdata);
endinterface

// File: rtl/instr_fetch_queue.sv
// Prefetches 16-bit instructions into an in-order {addr,data} queue and loads IR/ir_pc on each IR_E rise.
// Latency: mem_req one edge after the issue decision; IR loads one edge after IR_E, or on the mem_rvalid edge when bypassing.
// Backpressure: no request while halted or when the queue plus the outstanding read would exceed DEPTH; IR_E on an empty queue waits as ir_pending.
// Ports: CLK, rst_n | IR_E, redirect, redirect_pc, halt (controller in) | mem (memory read port)
//        | IR, ir_pc, ir_ack, ir_pending, q_count (controller out)
module instr_fetch_queue #(
   parameter int                 DEPTH    = 4,
   parameter int                 ADDR_W   = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic                     CLK,
   input  logic                     rst_n,
   input  logic                     IR_E,
   input  logic                     redirect,
   input  logic [ADDR_W-1:0]        redirect_pc,
   input  logic                     halt,
   instr_fetch_queue_if.master      mem,
   output logic [15:0]              IR,
   output logic [ADDR_W-1:0]        ir_pc,
   output logic                     ir_ack,
   output logic                     ir_pending,
   output logic [$clog2(DEPTH):0]   q_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

   state_t            state;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] q_addr [DEPTH];
   logic [15:0]       q_data [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic              ir_e_d;

   logic ir_e_rise;
   logic want_load;
   logic push;
   logic q_empty;
   logic load;
   logic bypass;
   logic pop;
   logic enq;
   logic issue;

   // A held IR_E level is one request; ir_pending carries a request that found the queue empty.
   assign ir_e_rise = IR_E & ~ir_e_d;
   assign want_load = ir_e_rise | ir_pending;
   assign push      = (state == WAIT) & mem.mem_rvalid & ~redirect;
   assign q_empty   = (q_count == '0);
   assign load      = want_load & ~redirect & (~q_empty | push);
   // Empty queue and data arriving now: hand it straight to IR instead of queueing it.
   assign bypass    = load & q_empty;
   assign pop       = load & ~q_empty;
   assign enq       = push & ~bypass;
   // Only IDLE issues, so nothing is outstanding here and q_count alone bounds the free slots.
   assign issue     = (state == IDLE) & ~halt & ~redirect & (q_count < CNT_W'(DEPTH));

   // Queue storage: data only, no reset needed. mem_addr still holds the address of the outstanding read.
   always_ff @(posedge CLK) begin
      if (enq) begin
         q_addr[wr_ptr] <= mem.mem_addr;
         q_data[wr_ptr] <= mem.mem_rdata;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         fetch_pc     <= RESET_PC;
         mem.mem_req  <= 1'b0;
         mem.mem_addr <= RESET_PC;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         q_count      <= '0;
         IR           <= 16'h0000;
         ir_pc        <= '0;
         ir_ack       <= 1'b0;
         ir_pending   <= 1'b0;
         ir_e_d       <= 1'b0;
      end else begin
         ir_e_d      <= IR_E;
         mem.mem_req <= 1'b0;
         ir_ack      <= load;

         case (state)
            IDLE: begin
               // mem_rvalid here is a protocol error and is ignored.
               if (issue) begin
                  mem.mem_req  <= 1'b1;
                  mem.mem_addr <= fetch_pc;
                  fetch_pc     <= fetch_pc + 1'b1;
                  state        <= WAIT;
               end
            end
            WAIT: begin
               if (redirect) begin
                  // Data returning on the redirect cycle belongs to the old stream.
                  state <= mem.mem_rvalid ? IDLE : DISCARD;
               end else if (mem.mem_rvalid) begin
                  state <= IDLE;
               end
            end
            DISCARD: begin
               if (mem.mem_rvalid) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (redirect) begin
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            q_count  <= '0;
         end else begin
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            if (enq) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            q_count <= q_count + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, pop};
         end

         if (bypass) begin
            IR    <= mem.mem_rdata;
            ir_pc <= mem.mem_addr;
         end else if (pop) begin
            IR    <= q_data[rd_ptr];
            ir_pc <= q_addr[rd_ptr];
         end

         // A request coinciding with redirect survives and is served from the new stream.
         if (redirect) begin
            ir_pending <= want_load;
         end else if (load) begin
            ir_pending <= 1'b0;
         end else if (want_load) begin
            ir_pending <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: table of controller actions, hand sequences for multi-cycle corners,
// and a randomized run checked by a stream model (each IR must be the next address of the current stream).
module tb_instr_fetch_queue;
   logic        CLK = 1'b0;
   logic        rst_n;
   logic        IR_E;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halt;
   logic [15:0] IR;
   logic [15:0] ir_pc;
   logic        ir_ack;
   logic        ir_pending;
   logic [2:0]  q_count;

   instr_fetch_queue_if #(.ADDR_W(16)) mif ();

   instr_fetch_queue #(.DEPTH(4), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .CLK         (CLK),
      .rst_n       (rst_n),
      .IR_E        (IR_E),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .mem         (mif),
      .IR          (IR),
      .ir_pc       (ir_pc),
      .ir_ack      (ir_ack),
      .ir_pending  (ir_pending),
      .q_count     (q_count)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;
   int n_req = 0;
   int n_ack = 0;
   int lat_cfg = 1;
   bit lat_rand = 1'b0;

   function automatic logic [15:0] memf(input logic [15:0] a);
      return 16'h0800 + a;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Program memory: in-order, one read at a time, latency counted in whole cycles after mem_req.
   initial begin
      bit          pend = 1'b0;
      int          cnt = 0;
      logic [15:0] paddr = 16'h0;
      mif.mem_rvalid = 1'b0;
      mif.mem_rdata  = 16'h0;
      forever begin
         @(negedge CLK);
         mif.mem_rvalid = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               cnt--;
               if (cnt <= 0) begin
                  mif.mem_rvalid = 1'b1;
                  mif.mem_rdata  = memf(paddr);
                  pend = 1'b0;
               end
            end
            if (mif.mem_req) begin
               check("one_outstanding", 32'(pend), 32'd0);
               pend  = 1'b1;
               paddr = mif.mem_addr;
               cnt   = lat_rand ? int'($urandom_range(1, 4)) : lat_cfg;
               n_req++;
            end
         end
      end
   end

   // Stream model: IR values arrive as consecutive addresses of the current stream; redirect starts a new one.
   initial begin
      logic [15:0] exp_pc = 16'h0000;
      logic [2:0]  q_prev = 3'd0;
      logic        r;
      logic        h;
      logic [15:0] rp;
      forever begin
         @(posedge CLK);
         r  = redirect;
         rp = redirect_pc;
         h  = halt;
         #1;
         if (!rst_n) begin
            exp_pc = 16'h0000;
         end else begin
            if (mif.mem_req) begin
               check("req_while_halt", 32'(h), 32'd0);
               check("req_no_room", 32'(q_prev < 3'd4), 32'd1);
            end
            if (ir_ack) begin
               n_ack++;
               check("stream_ir_pc", 32'(ir_pc), 32'(exp_pc));
               check("stream_ir", 32'(IR), 32'(memf(exp_pc)));
               exp_pc = exp_pc + 16'd1;
            end
            if (r) begin
               exp_pc = rp;
            end
         end
         q_prev = q_count;
      end
   end

   task automatic do_reset(input bit h);
      @(negedge CLK);
      #2 rst_n = 1'b0;
      IR_E = 1'b0;
      redirect = 1'b0;
      halt = h;
      repeat (2) @(negedge CLK);
      rst_n = 1'b1;
   endtask

   task automatic pulse(input bit e, input bit r, input logic [15:0] pc);
      @(negedge CLK);
      IR_E = e;
      redirect = r;
      redirect_pc = pc;
      @(negedge CLK);
      IR_E = 1'b0;
      redirect = 1'b0;
   endtask

   task automatic wait_req(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge CLK);
         if (mif.mem_req) seen = 1'b1;
      end
      check(nm, 32'(seen), 32'd1);
   endtask

   task automatic wait_ack(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge CLK);
         if (ir_ack) seen = 1'b1;
      end
      check(nm, 32'(seen), 32'd1);
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, "_IR"}, 32'(IR), 32'h0);
      check({nm, "_ir_pc"}, 32'(ir_pc), 32'h0);
      check({nm, "_ir_ack"}, 32'(ir_ack), 32'h0);
      check({nm, "_ir_pending"}, 32'(ir_pending), 32'h0);
      check({nm, "_mem_req"}, 32'(mif.mem_req), 32'h0);
      check({nm, "_mem_addr"}, 32'(mif.mem_addr), 32'h0);
      check({nm, "_q_count"}, 32'(q_count), 32'h0);
   endtask

   typedef struct {
      bit          ir_e;
      bit          redir;
      logic [15:0] rpc;
      int          wait_cyc;
      logic [15:0] exp_ir;
      logic [15:0] exp_pc;
      logic [2:0]  exp_q;
   } vec_t;

   vec_t vec [10];

   initial begin
      bit   seen_drop;
      int   req_snap;
      // Each row: one controller action, then settle; the queue refills to 4 with a 1-cycle memory.
      vec[0] = '{1'b0, 1'b0, 16'h0000, 20, 16'h0000, 16'h0000, 3'd4};
      vec[1] = '{1'b1, 1'b0, 16'h0000, 20, 16'h0800, 16'h0000, 3'd4};
      vec[2] = '{1'b1, 1'b0, 16'h0000, 20, 16'h0801, 16'h0001, 3'd4};
      vec[3] = '{1'b1, 1'b0, 16'h0000, 20, 16'h0802, 16'h0002, 3'd4};
      vec[4] = '{1'b0, 1'b1, 16'h0040, 24, 16'h0802, 16'h0002, 3'd4};
      vec[5] = '{1'b1, 1'b0, 16'h0000, 20, 16'h0840, 16'h0040, 3'd4};
      vec[6] = '{1'b1, 1'b1, 16'h0100, 24, 16'h0900, 16'h0100, 3'd4};
      vec[7] = '{1'b1, 1'b1, 16'hFFFF, 24, 16'h07FF, 16'hFFFF, 3'd4};
      vec[8] = '{1'b1, 1'b0, 16'h0000, 20, 16'h0800, 16'h0000, 3'd4};
      vec[9] = '{1'b1, 1'b0, 16'h0000, 20, 16'h0801, 16'h0001, 3'd4};

      rst_n = 1'b1;
      IR_E = 1'b0;
      redirect = 1'b0;
      redirect_pc = 16'h0;
      halt = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge CLK);
      check_reset_outputs("reset");
      @(negedge CLK);
      rst_n = 1'b1;

      // Table: fill, in-order loads, redirect, redirect+IR_E, address wrap.
      for (int i = 0; i < 10; i++) begin
         pulse(vec[i].ir_e, vec[i].redir, vec[i].rpc);
         repeat (vec[i].wait_cyc) @(negedge CLK);
         check($sformatf("vec%0d_IR", i), 32'(IR), 32'(vec[i].exp_ir));
         check($sformatf("vec%0d_ir_pc", i), 32'(ir_pc), 32'(vec[i].exp_pc));
         check($sformatf("vec%0d_q_count", i), 32'(q_count), 32'(vec[i].exp_q));
         check($sformatf("vec%0d_pending", i), 32'(ir_pending), 32'd0);
         check($sformatf("vec%0d_mem_req_full", i), 32'(mif.mem_req), 32'd0);
      end

      // Empty queue, slow memory: IR_E waits as ir_pending, then loads via bypass.
      lat_cfg = 6;
      do_reset(1'b1);
      repeat (5) @(negedge CLK);
      check("byp_q_empty", 32'(q_count), 32'd0);
      @(negedge CLK);
      halt = 1'b0;
      IR_E = 1'b1;
      @(negedge CLK);
      IR_E = 1'b0;
      check("byp_pending_set", 32'(ir_pending), 32'd1);
      seen_drop = 1'b0;
      begin
         bit got = 1'b0;
         for (int i = 0; i < 30 && !got; i++) begin
            @(negedge CLK);
            if (ir_ack) got = 1'b1;
            else if (!ir_pending) seen_drop = 1'b1;
         end
         check("byp_ack_seen", 32'(got), 32'd1);
      end
      check("byp_pending_held", 32'(seen_drop), 32'd0);
      check("byp_IR", 32'(IR), 32'h0800);
      check("byp_ir_pc", 32'(ir_pc), 32'h0000);
      check("byp_q_count", 32'(q_count), 32'd0);
      check("byp_pending_clr", 32'(ir_pending), 32'd0);
      @(negedge CLK);
      check("byp_ack_single", 32'(ir_ack), 32'd0);

      // Redirect while a read is outstanding: the returning data must be dropped.
      lat_cfg = 1;
      do_reset(1'b0);
      repeat (20) @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
         pulse(1'b1, 1'b0, 16'h0);
         repeat (10) @(negedge CLK);
      end
      check("disc_IR_before", 32'(IR), 32'h0803);
      lat_cfg = 10;
      pulse(1'b1, 1'b0, 16'h0);
      wait_req("disc_req8_seen");
      check("disc_req8_addr", 32'(mif.mem_addr), 32'h0008);
      pulse(1'b0, 1'b1, 16'h0040);
      check("disc_q_flushed", 32'(q_count), 32'd0);
      lat_cfg = 1;
      repeat (40) @(negedge CLK);
      check("disc_refilled", 32'(q_count), 32'd4);
      pulse(1'b1, 1'b0, 16'h0);
      repeat (3) @(negedge CLK);
      check("disc_IR", 32'(IR), 32'h0840);
      check("disc_ir_pc", 32'(ir_pc), 32'h0040);

      // Halt with one read in flight, drain, resume, then asynchronous reset mid-read.
      lat_cfg = 4;
      do_reset(1'b0);
      wait_req("halt_first_req");
      halt = 1'b1;
      req_snap = n_req;
      repeat (12) @(negedge CLK);
      check("halt_no_new_req", n_req, req_snap);
      check("halt_q_one", 32'(q_count), 32'd1);
      pulse(1'b1, 1'b0, 16'h0);
      repeat (3) @(negedge CLK);
      check("halt_IR", 32'(IR), 32'h0800);
      check("halt_ir_pc", 32'(ir_pc), 32'h0000);
      check("halt_q_drained", 32'(q_count), 32'd0);
      pulse(1'b1, 1'b0, 16'h0);
      repeat (3) @(negedge CLK);
      check("halt_pending", 32'(ir_pending), 32'd1);
      halt = 1'b0;
      wait_ack("resume_ack_seen");
      check("resume_IR", 32'(IR), 32'h0801);
      check("resume_ir_pc", 32'(ir_pc), 32'h0001);
      lat_cfg = 6;
      wait_req("arst_req_seen");
      #3 rst_n = 1'b0;
      #1;
      check_reset_outputs("arst");
      repeat (2) @(negedge CLK);
      rst_n = 1'b1;

      // Randomized traffic against the stream model.
      lat_rand = 1'b1;
      do_reset(1'b0);
      n_ack = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         IR_E = ($urandom_range(0, 99) < 40);
         redirect = ($urandom_range(0, 99) < 4);
         redirect_pc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                                   : 16'($urandom);
         if ($urandom_range(0, 99) < 5) halt = ~halt;
      end
      @(negedge CLK);
      IR_E = 1'b0;
      redirect = 1'b0;
      halt = 1'b0;
      repeat (40) @(negedge CLK);
      check("rand_activity", 32'(n_ack > 100), 32'd1);
      check("rand_drain_pending", 32'(ir_pending), 32'd0);
      check("rand_drain_full", 32'(q_count), 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
